// File: rtl/riscv_pkg.sv
// Shared constants and types for the RV32I core front end.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t IDLE = 2'd0;  // nothing outstanding
  localparam fetch_state_t WAIT = 2'd1;  // response wanted
  localparam fetch_state_t DROP = 2'd2;  // response will be discarded

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, a pending skid entry beats
// a fresh memory word, and with nothing to load a bubble is inserted.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic            i_stall,
  input  logic            i_load_skid,
  input  logic            i_load_mem,
  input  logic [XLEN-1:0] i_skid_instr,
  input  logic [XLEN-1:0] i_skid_pc,
  input  logic [XLEN-1:0] i_mem_instr,
  input  logic [XLEN-1:0] i_mem_pc,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_valid
);

  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus4;
  logic            r_valid;

  // NOTE: non-blocking assignments keep every register sampling pre-edge
  // values, so ordering inside the block cannot create simulation races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr    <= NOP_INSTR;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (!i_stall) begin
      if (i_load_skid) begin
        r_instr    <= i_skid_instr;
        r_pc       <= i_skid_pc;
        r_pc_plus4 <= i_skid_pc + 32'd4;
        r_valid    <= 1'b1;
      end else if (i_load_mem) begin
        r_instr    <= i_mem_instr;
        r_pc       <= i_mem_pc;
        r_pc_plus4 <= i_mem_pc + 32'd4;
        r_valid    <= 1'b1;
      end else begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end
    end
  end

  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PCF, one-outstanding imem FSM, 1-entry skid buffer
// for words that arrive while decode is stalled, and the IF/ID register.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  logic [XLEN-1:0] r_pcf;
  fetch_state_t    r_state;
  logic            r_skid_valid;
  fetch_entry_t    r_skid;

  logic [XLEN-1:0] w_pcf_plus4;
  logic            w_rsp_in_wait;
  logic            w_accept;
  logic            w_req;
  logic            w_skid_fill;
  logic            w_skid_drain;
  fetch_state_t    w_state_next;

  assign w_pcf_plus4   = r_pcf + 32'd4;
  assign w_rsp_in_wait = (r_state == WAIT) && imem_rvalid;
  // A response landing together with a redirect belongs to the old path.
  assign w_accept      = w_rsp_in_wait && !PCSrcE;

  assign w_req = !rst && !StallF && !PCSrcE && !r_skid_valid &&
                 ((r_state == IDLE) || (w_rsp_in_wait && !StallD));

  assign imem_req  = w_req;
  assign imem_addr = w_rsp_in_wait ? w_pcf_plus4 : r_pcf;

  assign w_skid_fill  = w_accept && (StallD || r_skid_valid);
  assign w_skid_drain = r_skid_valid && !FlushD && !StallD;

  // NOTE: default assignment first so every path drives w_state_next and
  // no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_req) w_state_next = WAIT;
      WAIT: begin
        if (PCSrcE)           w_state_next = imem_rvalid ? IDLE : DROP;
        else if (imem_rvalid) w_state_next = w_req ? WAIT : IDLE;
      end
      DROP: if (imem_rvalid) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcf        <= RESET_PC;
      r_state      <= IDLE;
      r_skid_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (PCSrcE)        r_pcf <= {PCTargetE[31:2], 2'b00};
      else if (w_accept) r_pcf <= w_pcf_plus4;

      if (PCSrcE)            r_skid_valid <= 1'b0;
      else if (w_skid_fill)  r_skid_valid <= 1'b1;
      else if (w_skid_drain) r_skid_valid <= 1'b0;
    end
  end

  // NOTE: skid payload is qualified by r_skid_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_skid_fill) begin
      r_skid.instr <= imem_rdata;
      r_skid.pc    <= r_pcf;
    end
  end

  if_id_reg u_if_id_reg (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (FlushD),
    .i_stall      (StallD),
    .i_load_skid  (r_skid_valid),
    .i_load_mem   (w_accept && !r_skid_valid),
    .i_skid_instr (r_skid.instr),
    .i_skid_pc    (r_skid.pc),
    .i_mem_instr  (imem_rdata),
    .i_mem_pc     (r_pcf),
    .o_instr      (InstrD),
    .o_pc         (PCD),
    .o_pc_plus4   (PCPlus4D),
    .o_valid      (ValidD)
  );

  a_no_rvalid_in_idle : assert property (
    @(posedge clk) disable iff (rst) !((r_state == IDLE) && imem_rvalid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural variable-latency imem.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req, imem_rvalid, ValidD;
  logic [31:0] imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;
  logic        w_req, w_rvalid, w_ValidD;
  logic [31:0] w_addr, w_rdata, w_InstrD, w_PCD, w_PCPlus4D;

  int checks   = 0;
  int failures = 0;
  int lat      = 1;  // rvalid arrives lat cycles after the request cycle

  always #5 clk = ~clk;

  fetch_stage u_dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(w_req),
    .imem_addr(w_addr), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .InstrD(w_InstrD), .PCD(w_PCD), .PCPlus4D(w_PCPlus4D), .ValidD(w_ValidD)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[23:0], 8'h33};
  endfunction

  logic        m_busy;
  int          m_cnt;
  logic [31:0] m_addr;

  always @(posedge clk) begin
    if (rst) begin
      m_busy      <= 1'b0;
      imem_rvalid <= 1'b0;
    end else begin
      imem_rvalid <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= instr_of(m_addr);
          m_busy      <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
      if (imem_req) begin
        if (lat == 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= instr_of(imem_addr);
        end else begin
          m_busy <= 1'b1;
          m_cnt  <= lat - 1;
          m_addr <= imem_addr;
        end
      end
    end
  end

  always @(posedge clk) begin
    w_rvalid <= !rst && w_req;
    w_rdata  <= instr_of(w_addr);
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int l);
    rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    PCSrcE = 1'b0; PCTargetE = '0; lat = l;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    PCSrcE = 1'b0; PCTargetE = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({imem_req, w_req} !== 2'b00) begin
      failures++; $display("FAIL reset_req: got %b want 00", {imem_req, w_req});
    end
    checks++;
    if ({InstrD, PCD, PCPlus4D, ValidD} !== {NOP, 32'h0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_d: got instr=%h pc=%h pc4=%h v=%b want %h/0/0/0",
               InstrD, PCD, PCPlus4D, ValidD, NOP);
    end
  endtask

  task automatic test_one_cycle;
    logic [31:0] pc;
    apply_reset(1);
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'(4 * k)}) begin
        failures++;
        $display("FAIL b2b_addr k=%0d: got req=%b addr=%h want 1/%h", k, imem_req, imem_addr, 4 * k);
      end
      if (k >= 2) begin
        pc = 32'(4 * (k - 2));
        checks++;
        if ({ValidD, PCD, PCPlus4D, InstrD} !== {1'b1, pc, pc + 32'd4, instr_of(pc)}) begin
          failures++;
          $display("FAIL b2b_d k=%0d: got v=%b pc=%h pc4=%h instr=%h want pc=%h",
                   k, ValidD, PCD, PCPlus4D, InstrD, pc);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_wrap;
    apply_reset(1);
    #1;
    checks++;
    if ({w_req, w_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      failures++; $display("FAIL wrap_first: got req=%b addr=%h want 1/fffffffc", w_req, w_addr);
    end
    next_cycle(); #1;
    checks++;
    if ({w_req, w_addr} !== {1'b1, 32'h0}) begin
      failures++; $display("FAIL wrap_second: got req=%b addr=%h want 1/00000000", w_req, w_addr);
    end
    next_cycle(); #1;
    checks++;
    if ({w_ValidD, w_PCD, w_PCPlus4D} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
      failures++;
      $display("FAIL wrap_d: got v=%b pc=%h pc4=%h want 1/fffffffc/0", w_ValidD, w_PCD, w_PCPlus4D);
    end
  endtask

  // Three dead cycles between request and response: one fetch every 4 cycles.
  task automatic test_slow_mem;
    logic        exp_req, exp_v;
    logic [31:0] exp_pc;
    apply_reset(4);
    for (int k = 0; k < 14; k++) begin
      #1;
      exp_req = (k % 4 == 0);
      checks++;
      if (imem_req !== exp_req || (exp_req && imem_addr !== 32'(4 * (k / 4)))) begin
        failures++;
        $display("FAIL slow_req k=%0d: got req=%b addr=%h want req=%b addr=%h",
                 k, imem_req, imem_addr, exp_req, 4 * (k / 4));
      end
      exp_v  = (k >= 5) && (k % 4 == 1);
      exp_pc = (k >= 5) ? 32'(4 * ((k - 5) / 4)) : 32'h0;
      checks++;
      if (ValidD !== exp_v || InstrD !== (exp_v ? instr_of(exp_pc) : NOP) ||
          (exp_v && PCD !== exp_pc)) begin
        failures++;
        $display("FAIL slow_d k=%0d: got v=%b instr=%h pc=%h want v=%b pc=%h", k, ValidD, InstrD, PCD, exp_v, exp_pc);
      end
      next_cycle();
    end
  endtask

  task automatic test_stall;
    apply_reset(1);
    next_cycle(); next_cycle();
    StallF = 1'b1; StallD = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++; $display("FAIL stall_req: got %b want 0", imem_req);
    end
    next_cycle(); #1;
    checks++;
    if ({ValidD, PCD, InstrD} !== {1'b1, 32'h0, instr_of(32'h0)}) begin
      failures++; $display("FAIL stall_hold1: got v=%b pc=%h instr=%h want 1/0/%h", ValidD, PCD, InstrD, instr_of(32'h0));
    end
    next_cycle();
    StallF = 1'b0; StallD = 1'b0;
    #1;
    checks++;
    if ({imem_req, PCD, InstrD} !== {1'b0, 32'h0, instr_of(32'h0)}) begin
      failures++; $display("FAIL stall_release: got req=%b pc=%h instr=%h want 0/0/%h", imem_req, PCD, InstrD, instr_of(32'h0));
    end
    next_cycle(); #1;
    checks++;
    if ({ValidD, PCD, InstrD} !== {1'b1, 32'h4, instr_of(32'h4)}) begin
      failures++; $display("FAIL stall_skid_out: got v=%b pc=%h instr=%h want 1/4/%h", ValidD, PCD, InstrD, instr_of(32'h4));
    end
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
      failures++; $display("FAIL stall_resume: got req=%b addr=%h want 1/8", imem_req, imem_addr);
    end
    next_cycle(); #1;
    checks++;
    if (ValidD !== 1'b0) begin
      failures++; $display("FAIL stall_bubble: got v=%b want 0", ValidD);
    end
    next_cycle(); #1;
    checks++;
    if ({ValidD, PCD, InstrD} !== {1'b1, 32'h8, instr_of(32'h8)}) begin
      failures++; $display("FAIL stall_next: got v=%b pc=%h instr=%h want 1/8/%h", ValidD, PCD, InstrD, instr_of(32'h8));
    end
  endtask

  task automatic test_redirect;
    int waited;
    apply_reset(4);
    next_cycle();
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0103;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++; $display("FAIL redir_req: got %b want 0", imem_req);
    end
    next_cycle();
    PCSrcE = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({imem_req, ValidD} !== 2'b00) begin
        failures++; $display("FAIL redir_drop k=%0d: got req=%b v=%b want 0/0", k, imem_req, ValidD);
      end
      next_cycle();
    end
    #1;
    checks++;
    if ({imem_req, imem_addr, ValidD, InstrD} !== {1'b1, 32'h100, 1'b0, NOP}) begin
      failures++;
      $display("FAIL redir_target: got req=%b addr=%h v=%b instr=%h want 1/100/0/%h", imem_req, imem_addr, ValidD, InstrD, NOP);
    end
    waited = 0;
    while (ValidD !== 1'b1 && waited < 10) begin
      next_cycle(); #1;
      waited++;
    end
    checks++;
    if ({ValidD, PCD, InstrD} !== {1'b1, 32'h100, instr_of(32'h100)}) begin
      failures++; $display("FAIL redir_fetch: got v=%b pc=%h instr=%h want 1/100/%h", ValidD, PCD, InstrD, instr_of(32'h100));
    end
  endtask

  // Redirect in the very cycle a response arrives, with decode flushed.
  task automatic test_back_to_back;
    apply_reset(1);
    next_cycle(); next_cycle();
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0040; FlushD = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++; $display("FAIL same_cycle_req: got %b want 0", imem_req);
    end
    next_cycle();
    PCSrcE = 1'b0; FlushD = 1'b0;
    #1;
    checks++;
    if ({imem_req, imem_addr, ValidD, InstrD} !== {1'b1, 32'h40, 1'b0, NOP}) begin
      failures++;
      $display("FAIL same_cycle_target: got req=%b addr=%h v=%b instr=%h want 1/40/0/%h", imem_req, imem_addr, ValidD, InstrD, NOP);
    end
    next_cycle(); next_cycle(); #1;
    checks++;
    if ({ValidD, PCD, InstrD} !== {1'b1, 32'h40, instr_of(32'h40)}) begin
      failures++; $display("FAIL same_cycle_fetch: got v=%b pc=%h instr=%h want 1/40/%h", ValidD, PCD, InstrD, instr_of(32'h40));
    end
  endtask

  task automatic test_reset_mid;
    apply_reset(1);
    next_cycle(); next_cycle(); next_cycle();
    #1;
    checks++;
    if ({ValidD, PCD} !== {1'b1, 32'h4}) begin
      failures++; $display("FAIL mid_pre: got v=%b pc=%h want 1/4", ValidD, PCD);
    end
    rst = 1'b1;
    next_cycle(); #1;
    checks++;
    if ({imem_req, InstrD, PCD, PCPlus4D, ValidD} !== {1'b0, NOP, 32'h0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset: got req=%b instr=%h pc=%h pc4=%h v=%b want 0/%h/0/0/0", imem_req, InstrD, PCD, PCPlus4D, ValidD, NOP);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      failures++; $display("FAIL mid_restart: got req=%b addr=%h want 1/0", imem_req, imem_addr);
    end
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_one_cycle();
    test_wrap();
    test_slow_mem();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
